// File: rtl/audioport_pkg.sv
// Shared constants and types for the audioport I2S blocks.
// The receiver's optional error counter is enabled with I2S_RX_ERR_COUNT_EN.
package audioport_pkg;

   localparam int AUDIO_BITS   = 24;
   localparam int I2S_SLOT_SCK = 24;
   localparam int ERR_CNT_BITS = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SYNC,
      RX_RUN
   } i2s_rx_state_t;

   // Saturating increment used by the frame-error counter.
   function automatic logic [ERR_CNT_BITS-1:0] sat_inc(input logic [ERR_CNT_BITS-1:0] v);
      sat_inc = (v == {ERR_CNT_BITS{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the external I2S pins into the clk domain and flags each rising sck edge.
// srise is high for exactly one clk cycle per sck period, aligned with ws_s/sdi_s.
module i2s_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sck_in,
   input  logic ws_in,
   input  logic sdi_in,
   output logic ws_s,
   output logic sdi_s,
   output logic srise
);

   logic sck_meta_q, sck_sync_q, sck_last_q;
   logic ws_meta_q,  ws_sync_q;
   logic sdi_meta_q, sdi_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_meta_q <= 1'b0;
         sck_sync_q <= 1'b0;
         sck_last_q <= 1'b0;
         ws_meta_q  <= 1'b0;
         ws_sync_q  <= 1'b0;
         sdi_meta_q <= 1'b0;
         sdi_sync_q <= 1'b0;
      end else begin
         sck_meta_q <= sck_in;
         sck_sync_q <= sck_meta_q;
         sck_last_q <= sck_sync_q;
         ws_meta_q  <= ws_in;
         ws_sync_q  <= ws_meta_q;
         sdi_meta_q <= sdi_in;
         sdi_sync_q <= sdi_meta_q;
      end
   end

   assign ws_s  = ws_sync_q;
   assign sdi_s = sdi_sync_q;
   assign srise = sck_sync_q & ~sck_last_q;

endmodule

// File: rtl/i2s_rx_unit.sv
// I2S receiver: deserializes 24-bit left/right slots into registered words with a pair tick.
// Define I2S_RX_ERR_COUNT_EN to build the saturating frame-error counter on err_count_out.
module i2s_rx_unit #(
   parameter int AUDIO_BITS = audioport_pkg::AUDIO_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sck_in,
   input  logic                  ws_in,
   input  logic                  sdi_in,
   input  logic                  enable_in,
   input  logic                  clr_in,
   output logic [AUDIO_BITS-1:0] audio0_out,
   output logic [AUDIO_BITS-1:0] audio1_out,
   output logic                  tick_out,
   output logic                  err_out,
   output logic [7:0]            err_count_out
);
   import audioport_pkg::*;

   localparam logic [4:0] CNT_LAST = 5'(I2S_SLOT_SCK - 1);

   logic ws_s, sdi_s, srise;

   i2s_rx_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sck_in (sck_in),
      .ws_in  (ws_in),
      .sdi_in (sdi_in),
      .ws_s   (ws_s),
      .sdi_s  (sdi_s),
      .srise  (srise)
   );

   i2s_rx_state_t         state_q, state_d;
   logic                  ws_q, ws_d;
   logic [AUDIO_BITS-1:0] shreg_q, shreg_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [AUDIO_BITS-1:0] left_q, left_d;
   logic [AUDIO_BITS-1:0] audio0_q, audio0_d;
   logic [AUDIO_BITS-1:0] audio1_q, audio1_d;
   logic                  tick_q, tick_d;
   logic                  err_q, err_d;
   logic                  frame_err;
   logic [AUDIO_BITS-1:0] word;

   assign word = {shreg_q[AUDIO_BITS-2:0], sdi_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RX_IDLE;
         ws_q     <= 1'b0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         left_q   <= '0;
         audio0_q <= '0;
         audio1_q <= '0;
         tick_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ws_q     <= ws_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         audio0_q <= audio0_d;
         audio1_q <= audio1_d;
         tick_q   <= tick_d;
         err_q    <= err_d;
      end
   end

   // ws_q tracks the bus in every state so SYNC can spot a 1->0 edge immediately.
   always_comb begin
      state_d   = state_q;
      ws_d      = ws_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      audio0_d  = audio0_q;
      audio1_d  = audio1_q;
      tick_d    = 1'b0;
      frame_err = 1'b0;

      if (srise) ws_d = ws_s;

      if (!enable_in) begin
         state_d = RX_IDLE;
         cnt_d   = '0;
         shreg_d = '0;
      end else begin
         case (state_q)
            RX_IDLE: begin
               cnt_d   = '0;
               shreg_d = '0;
               state_d = RX_SYNC;
            end
            RX_SYNC: begin
               if (srise && ws_q && !ws_s) begin
                  cnt_d   = '0;
                  state_d = RX_RUN;
               end
            end
            RX_RUN: begin
               if (srise) begin
                  if (ws_s == ws_q) begin
                     if (cnt_q == CNT_LAST) begin
                        frame_err = 1'b1;
                        state_d   = RX_SYNC;
                     end else begin
                        shreg_d = word;
                        cnt_d   = cnt_q + 5'd1;
                     end
                  end else if (cnt_q != CNT_LAST) begin
                     frame_err = 1'b1;
                     state_d   = RX_SYNC;
                  end else begin
                     // Slot boundary: this rise carried the LSB of the slot just ended.
                     shreg_d = word;
                     cnt_d   = '0;
                     if (ws_s) begin
                        left_d = word;
                     end else begin
                        audio0_d = left_q;
                        audio1_d = word;
                        tick_d   = 1'b1;
                     end
                  end
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   // A new error outranks a clear arriving in the same cycle.
   always_comb begin
      err_d = err_q;
      if (frame_err)   err_d = 1'b1;
      else if (clr_in) err_d = 1'b0;
   end

`ifdef I2S_RX_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err && clr_in) err_cnt_d = 8'd1;
      else if (frame_err)      err_cnt_d = sat_inc(err_cnt_q);
      else if (clr_in)         err_cnt_d = '0;
   end

   assign err_count_out = err_cnt_q;
`else
   assign err_count_out = 8'd0;
`endif

   assign audio0_out = audio0_q;
   assign audio1_out = audio1_q;
   assign tick_out   = tick_q;
   assign err_out    = err_q;

endmodule

// File: tb/tb_i2s_rx_unit.sv
// Directed bench for i2s_rx_unit: framing, latency, errors, enable drop and clear priority.
module tb_i2s_rx_unit;

   localparam int H = 4;  // clk cycles per sck half period

`ifdef I2S_RX_ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk, rst_n, sck_in, ws_in, sdi_in, enable_in, clr_in;
   logic [23:0] audio0_out, audio1_out;
   logic        tick_out, err_out;
   logic [7:0]  err_count_out;

   int total = 0;
   int bad = 0;
   int tick_total = 0;

   i2s_rx_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sck_in        (sck_in),
      .ws_in         (ws_in),
      .sdi_in        (sdi_in),
      .enable_in     (enable_in),
      .clr_in        (clr_in),
      .audio0_out    (audio0_out),
      .audio1_out    (audio1_out),
      .tick_out      (tick_out),
      .err_out       (err_out),
      .err_count_out (err_count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (tick_out === 1'b1) tick_total = tick_total + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sck_cycle(input logic w, input logic d);
      sck_in = 1'b0; ws_in = w; sdi_in = d;
      repeat (H) @(negedge clk);
      sck_in = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   // Left bits 23..1 (ws=0), left LSB with ws=1, right bits 23..1 (ws=1).
   task automatic body(input logic [23:0] l, input logic [23:0] r);
      for (int i = 23; i >= 1; i--) sck_cycle(1'b0, l[i]);
      sck_cycle(1'b1, l[0]);
      for (int i = 23; i >= 1; i--) sck_cycle(1'b1, r[i]);
   endtask

   // Final rise (ws=0, right LSB) with cycle-accurate tick checks after each clk edge.
   task automatic close_frame(input string tag, input logic d, input logic exp_tick,
                              input logic [23:0] l, input logic [23:0] r);
      sck_in = 1'b0; ws_in = 1'b0; sdi_in = d;
      repeat (H) @(negedge clk);
      sck_in = 1'b1;
      @(negedge clk); check({tag, "_tick_e0"}, 32'(tick_out), 32'd0);
      @(negedge clk); check({tag, "_tick_e1"}, 32'(tick_out), 32'd0);
      @(negedge clk); check({tag, "_tick_e2"}, 32'(tick_out), 32'(exp_tick));
      if (exp_tick) begin
         check({tag, "_audio0"}, 32'(audio0_out), 32'(l));
         check({tag, "_audio1"}, 32'(audio1_out), 32'(r));
      end
      @(negedge clk); check({tag, "_tick_e3"}, 32'(tick_out), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; enable_in = 1'b0; clr_in = 1'b0;
      sck_in = 1'b0; ws_in = 1'b0; sdi_in = 1'b0;

      // Reset and disabled operation while the bus toggles.
      sck_cycle(1'b1, 1'b1);
      sck_cycle(1'b0, 1'b1);
      check("rst_tick", 32'(tick_out), 32'd0);
      check("rst_audio0", 32'(audio0_out), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      sck_cycle(1'b1, 1'b0);
      body(24'h111111, 24'h222222);
      close_frame("disabled", 1'b0, 1'b0, 24'h0, 24'h0);
      check("dis_audio0", 32'(audio0_out), 32'd0);
      check("dis_audio1", 32'(audio1_out), 32'd0);
      check("dis_err", 32'(err_out), 32'd0);
      check("dis_errcnt", 32'(err_count_out), 32'd0);
      check("dis_ticks", 32'(tick_total), 32'd0);

      // Enable, sync, two good frames.
      @(negedge clk) enable_in = 1'b1;
      sck_cycle(1'b1, 1'b0);
      sck_cycle(1'b1, 1'b0);
      close_frame("sync", 1'b0, 1'b0, 24'h0, 24'h0);
      body(24'h123456, 24'hABCDEF);
      close_frame("f1", 1'b1, 1'b1, 24'h123456, 24'hABCDEF);
      body(24'h800001, 24'h7FFFFF);
      close_frame("f2", 1'b1, 1'b1, 24'h800001, 24'h7FFFFF);
      check("f2_ticks", 32'(tick_total), 32'd2);
      check("f2_err", 32'(err_out), 32'd0);

      // Left slot of only 23 bits.
      repeat (22) sck_cycle(1'b0, 1'b1);
      repeat (24) sck_cycle(1'b1, 1'b0);
      check("short_err", 32'(err_out), 32'd1);
      check("short_errcnt", 32'(err_count_out), CNT_EN ? 32'd1 : 32'd0);
      close_frame("short_resync", 1'b0, 1'b0, 24'h0, 24'h0);
      check("short_ticks", 32'(tick_total), 32'd2);
      body(24'h00000F, 24'hF00000);
      close_frame("f3", 1'b0, 1'b1, 24'h00000F, 24'hF00000);
      check("f3_ticks", 32'(tick_total), 32'd3);

      // Lone clear.
      @(negedge clk) clr_in = 1'b1;
      @(negedge clk) clr_in = 1'b0;
      check("clr1_err", 32'(err_out), 32'd0);
      check("clr1_errcnt", 32'(err_count_out), 32'd0);

      // Enable dropped for one clk in the middle of the right slot.
      for (int i = 23; i >= 1; i--) sck_cycle(1'b0, 1'b1);
      sck_cycle(1'b1, 1'b0);
      for (int i = 23; i >= 12; i--) sck_cycle(1'b1, 1'b1);
      enable_in = 1'b0;
      @(negedge clk) enable_in = 1'b1;
      for (int i = 11; i >= 1; i--) sck_cycle(1'b1, 1'b0);
      close_frame("drop", 1'b0, 1'b0, 24'h0, 24'h0);
      check("drop_audio0", 32'(audio0_out), 32'h00000F);
      body(24'hC0FFEE, 24'h135790);
      close_frame("f4", 1'b0, 1'b1, 24'hC0FFEE, 24'h135790);
      check("f4_ticks", 32'(tick_total), 32'd4);
      check("f4_err", 32'(err_out), 32'd0);

      // Clear in the same cycle as a new error: the error wins.
      repeat (5) sck_cycle(1'b0, 1'b0);
      sck_in = 1'b0; ws_in = 1'b1; sdi_in = 1'b0;
      repeat (H) @(negedge clk);
      sck_in = 1'b1;
      @(negedge clk);
      @(negedge clk) clr_in = 1'b1;
      @(negedge clk) clr_in = 1'b0;
      check("clr_err_race", 32'(err_out), 32'd1);
      check("clr_cnt_race", 32'(err_count_out), CNT_EN ? 32'd1 : 32'd0);
      @(negedge clk);
      check("race_ticks", 32'(tick_total), 32'd4);
      check("hold_audio0", 32'(audio0_out), 32'hC0FFEE);
      check("hold_audio1", 32'(audio1_out), 32'h135790);
      @(negedge clk) clr_in = 1'b1;
      @(negedge clk) clr_in = 1'b0;
      check("clr2_err", 32'(err_out), 32'd0);

`ifdef I2S_RX_ERR_COUNT_EN
      // 300 short frames saturate the counter.
      repeat (300) begin
         sck_cycle(1'b1, 1'b0);
         sck_cycle(1'b0, 1'b0);
         sck_cycle(1'b0, 1'b0);
         sck_cycle(1'b1, 1'b0);
      end
      check("sat_errcnt", 32'(err_count_out), 32'd255);
      check("sat_err", 32'(err_out), 32'd1);
      check("sat_ticks", 32'(tick_total), 32'd4);
      @(negedge clk) clr_in = 1'b1;
      @(negedge clk) clr_in = 1'b0;
      check("sat_clr_cnt", 32'(err_count_out), 32'd0);
      check("sat_clr_err", 32'(err_out), 32'd0);
`else
      check("nocnt_errcnt", 32'(err_count_out), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_rx_unit.md
# i2s_rx_unit

I2S receiver: the receive-side counterpart of the audioport `i2s_unit` transmitter. Samples an external I2S bus (`sck_in`, `ws_in`, `sdi_in`) with the system clock and deserializes 24-bit left/right samples. Presents each completed stereo pair as registered words plus a one-cycle `tick_out`. Sits between the board audio input pins and a DSP or control unit in the `clk` domain, and detects frame errors.

## Interface
Parameters:
- `AUDIO_BITS`, 24, bits per channel slot (taken from `audioport_pkg`)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `sck_in`  in  1  I2S bit clock, asynchronous to `clk`
- `ws_in`  in  1  word select: 0 = left (audio0), 1 = right (audio1)
- `sdi_in`  in  1  serial data, MSB first
- `enable_in`  in  1  receiver enable, level
- `clr_in`  in  1  clears `err_out` (and the error counter), one-cycle pulse
- `audio0_out`  out  24  last complete left sample
- `audio1_out`  out  24  last complete right sample
- `tick_out`  out  1  one-cycle pulse: new pair valid
- `err_out`  out  1  sticky frame-error flag
- `err_count_out`  out  8  saturating frame-error count (see Configuration)

## Operation
- `sck_in`, `ws_in` and `sdi_in` each pass through a 2-flop synchronizer.
- A third `sck` flop detects the rising edge `srise`. All of the following happens only on `srise`.
- Bus format is standard I2S:
  - `ws` and `sdi` change on the falling `sck` edge.
  - `ws` changes one `sck` before the MSB, so the bit sampled on the first rise with new `ws` is the LSB of the previous slot.
  - 24 `sck` per slot, 48 per frame.
- Registers:
  - `ws_q`: `ws` sampled at the previous `srise`.
  - `shreg[23:0]`.
  - `cnt[4:0]`: bits shifted in the current slot.
  - `left_hold[23:0]`.
- FSM states: IDLE, SYNC, RUN.
  - IDLE: entered on reset or whenever `enable_in`=0 (this has priority in any state). Clears `cnt` and `shreg`. Outputs hold. Goes to SYNC when `enable_in`=1.
  - SYNC: waits for an `srise` with `ws` 1→0. That sampled bit is discarded, `cnt`←0, go to RUN.
  - RUN, `srise` without a `ws` change: `shreg`←{`shreg[22:0]`,`sdi`}, `cnt`++.
    - If `cnt` would reach 24, it is a frame error and the FSM goes to SYNC.
  - RUN, `srise` with a `ws` change: `word`={`shreg[22:0]`,`sdi`}.
    - Valid only if `cnt`==23; otherwise frame error → SYNC.
    - On a 0→1 change: `left_hold`←`word`.
    - On a 1→0 change: `audio0_out`←`left_hold`, `audio1_out`←`word`, pulse `tick_out`.
    - `cnt`←0 in both cases.
- Frame error:
  - `err_out`←1, with no tick for that frame.
  - Resync waits for the next `ws` 1→0 edge.
- `clr_in` clears `err_out`. If a new error occurs in the same cycle, the error wins and `err_out` stays 1.
- The first frame after SYNC is always a full left+right pair. A partial frame is never output.

## Timing
- Reset values: `audio0_out`=0, `audio1_out`=0, `tick_out`=0, `err_out`=0, `err_count_out`=0. FSM=IDLE, all internal registers 0.
- `clk` must be ≥4× `sck`, with `sck` high and low each ≥2 `clk` periods. No checking below that ratio.
- Latency: `tick_out` and the new audio words become visible 2 `clk` cycles after the first `clk` edge that samples `sck_in` high on the final (LSB of right) rise.
- `tick_out` is high for exactly 1 `clk` cycle per frame.
- Audio outputs are stable from `tick_out` until the next `tick_out`.
- Deasserting `enable_in` mid-frame:
  - Takes effect on the next `clk` edge.
  - The pending frame is discarded and no tick is issued.
- Reset mid-frame discards everything.

## Configuration
- `I2S_RX_ERR_COUNT_EN` defined:
  - 8-bit counter increments on each frame error and saturates at 255.
  - Cleared by `clr_in`; a simultaneous error leaves it at 1.
- Not defined: `err_count_out` is tied to 0 and no counter logic is present.

## Structure
- In `audioport_pkg`:
  - `AUDIO_BITS`=24.
  - `I2S_SLOT_SCK`=24.
  - `typedef enum logic [1:0] {RX_IDLE, RX_SYNC, RX_RUN} i2s_rx_state_t`.
- One sub-module `i2s_rx_sync`: 2-flop synchronizer for the three inputs plus the `sck` rise detector. Outputs are `ws_s`, `sdi_s` and `srise`.

## Test plan
- Reset with `enable_in`=0 while the bus toggles → all outputs 0, no tick.
- Enable, one sync frame, then frames L=0x123456 R=0xABCDEF and L=0x800001 R=0x7FFFFF → exactly 2 ticks with those values, each tick 2 `clk` after the final `sck` rise.
- Left slot shortened to 23 bits → `err_out`=1, no tick for that frame; next good frame L=0x00000F R=0xF00000 → tick with those values.
- `enable_in` dropped for 1 cycle mid-right-slot → no tick for that frame; the frame after the next `ws` 1→0 is received correctly.
- `clr_in` pulsed in the same cycle as a new error → `err_out` stays 1; a later lone `clr_in` → `err_out`=0.
- With `I2S_RX_ERR_COUNT_EN`: 300 bad frames → `err_count_out`=255; `clr_in` → 0. Without the macro, `err_count_out` is always 0.
